// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a length-prefixed, XOR-checked program into instruction memory, then enables the core
module imem_boot_loader #(
    parameter int IMEM_WORDS = 128,
    parameter int LEN_W      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int WI = $clog2(IMEM_WORDS) + 1;
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LEN_LO = 3'd1;
    localparam logic [2:0] LEN_HI = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] CHECK  = 3'd5;
    localparam logic [2:0] RUN    = 3'd6;
    localparam logic [2:0] ERROR  = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d, n_full;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [WI-1:0]    widx_q, widx_d;
    logic [7:0]       xor_q, xor_d;
    logic [23:0]      bytes_q, bytes_d;
    logic [63:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             wen_q, wen_d, rdy_q, rdy_d, busy_q, busy_d;
    logic             cpu_en_q, cpu_en_d, done_q, done_d, err_q, err_d;
    logic             acc;

    assign rx_ready   = rdy_q;
    assign addr_ext   = addr_q;
    assign wen_ext    = wen_q;
    assign ren_ext    = 1'b0;
    assign wdata_ext  = wdata_q;
    assign cpu_enable = cpu_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = err_q;

    // Next state, datapath, and outputs derived from the next state so every output is a flop
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bcnt_d  = bcnt_q;
        widx_d  = widx_q;
        xor_d   = xor_q;
        bytes_d = bytes_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        acc     = rx_valid && rdy_q;
        n_full  = len_q | (LEN_W'(rx_data) << 8);
        case (state_q)
            IDLE, RUN, ERROR: if (start) begin
                state_d = LEN_LO;
                len_d   = '0;
                bcnt_d  = '0;
                widx_d  = '0;
                xor_d   = '0;
            end
            LEN_LO: if (acc) begin
                len_d   = LEN_W'(rx_data);
                state_d = LEN_HI;
            end
            LEN_HI: if (acc) begin
                len_d   = n_full;
                state_d = (n_full == '0 || n_full > LEN_W'(IMEM_WORDS)) ? ERROR : DATA;
            end
            DATA: if (acc) begin
                xor_d  = xor_q ^ rx_data;
                bcnt_d = bcnt_q + 2'd1;
                if (bcnt_q == 2'd3) begin
                    state_d = WRITE;
                    addr_d  = 64'({widx_q, 2'b00});
                    wdata_d = {rx_data, bytes_q};
                end else begin
                    bytes_d[{bcnt_q, 3'b000} +: 8] = rx_data;
                end
            end
            WRITE: begin
                widx_d  = widx_q + WI'(1);
                state_d = (LEN_W'(widx_q) + LEN_W'(1) == len_q) ? CHECK : DATA;
            end
            CHECK: if (acc) state_d = (rx_data == xor_q) ? RUN : ERROR;
            default: state_d = IDLE;
        endcase
        rdy_d    = state_d inside {LEN_LO, LEN_HI, DATA, CHECK};
        busy_d   = state_d inside {LEN_LO, LEN_HI, DATA, WRITE, CHECK};
        wen_d    = state_d == WRITE;
        cpu_en_d = state_d == RUN;
        err_d    = state_d == ERROR;
        done_d   = state_q == CHECK && state_d == RUN;
    end

    // State and output registers; reset overrides everything, including a write in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            bcnt_q   <= '0;
            widx_q   <= '0;
            xor_q    <= '0;
            bytes_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            cpu_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            bcnt_q   <= bcnt_d;
            widx_q   <= widx_d;
            xor_q    <= xor_d;
            bytes_q  <= bytes_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wen_q    <= wen_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            cpu_en_q <= cpu_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end
endmodule
